spi_resp_slave: RTL

//  SPI responder in the system clock domain: oversamples sclk/cs/mosi from an external

---
 rtl/spi_resp_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_resp_slave.sv
// Full-duplex SPI responder: oversamples sclk/cs/mosi in the clk_i domain, assembles
// LSB-first frames into rx_data_o and shifts a preloaded response word out on miso_o.
module spi_resp_slave #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FINISH = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;

  // cs synchronizer presets high so a released reset never looks like a frame start
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          cnt_d     = '0;
          rx_sr_d   = '0;
          miso_d    = 1'b0;
          tx_sr_d   = tx_full_q ? tx_buf_q : '0;
          tx_full_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          rx_sr_d     = '0;
          tx_sr_d     = '0;
          miso_d      = 1'b0;
        end else if (sclk_rise) begin
          miso_d  = tx_sr_q[0];
          tx_sr_d = tx_sr_q >> 1;
        end else if (sclk_fall) begin
          rx_sr_d = {mosi_s, rx_sr_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d    = FINISH;
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
          end
        end
      end
      FINISH: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // evaluated after the cs-fall consume so a same-cycle load lands in the next frame
    if (tx_load_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  assign miso_o      = (state_q == ACTIVE) ? miso_q : 1'b0;
  assign tx_ready_o  = ~tx_full_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule
